mul_iter_unit: RTL and testbench

- Iterative shift-and-add multiplier executing RV32M MUL, MULH, MULHSU and MULHU.
- Sits downstream of the integer adder datapath, beside the ALU in the execute stage, and reuses an adder-based accumulate step, one multiplier bit per cycle.
- Single-request, valid/ready handshake on both the request side and the result side. The core stalls on in_ready/out_valid.

---
 rtl/mul_iter_unit.sv | 153 +++++++++++++++
 tb/tb_mul_iter_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mul_iter_unit.sv
// Iterative shift-and-add multiplier for RV32M MUL/MULH/MULHSU/MULHU, one multiplier bit per cycle.
// Optional early termination on an exhausted multiplier is enabled by defining MUL_EARLY_TERM_EN.
module mul_iter_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_result
);

    localparam int unsigned PW   = 2 * XLEN;
    localparam int unsigned CntW = $clog2(XLEN) + 1;

    localparam logic [1:0] OpMul    = 2'b00;
    localparam logic [1:0] OpMulh   = 2'b01;
    localparam logic [1:0] OpMulhsu = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [PW-1:0]     r_acc;
    logic [PW-1:0]     w_acc_d;
    logic [PW-1:0]     r_mcand;
    logic [PW-1:0]     w_mcand_d;
    logic [XLEN-1:0]   r_mplier;
    logic [XLEN-1:0]   w_mplier_d;
    logic [CntW-1:0]   r_cnt;
    logic [CntW-1:0]   w_cnt_d;
    logic              r_neg;
    logic              w_neg_d;
    logic [1:0]        r_op;
    logic [1:0]        w_op_d;
    logic [XLEN-1:0]   r_result;
    logic [XLEN-1:0]   w_result_d;

    logic              w_rs1_signed;
    logic              w_rs2_signed;
    logic              w_rs1_neg;
    logic              w_rs2_neg;
    logic [XLEN-1:0]   w_rs1_mag;
    logic [XLEN-1:0]   w_rs2_mag;
    logic [PW-1:0]     w_product;
    logic              w_early;

    // Operand conditioning for the acceptance cycle; |0x80000000| stays 0x80000000 as unsigned.
    always_comb begin
        w_rs1_signed = (i_op == OpMulh) || (i_op == OpMulhsu);
        w_rs2_signed = (i_op == OpMulh);
        w_rs1_neg    = w_rs1_signed & i_rs1[XLEN-1];
        w_rs2_neg    = w_rs2_signed & i_rs2[XLEN-1];
        w_rs1_mag    = w_rs1_neg ? (~i_rs1 + 1'b1) : i_rs1;
        w_rs2_mag    = w_rs2_neg ? (~i_rs2 + 1'b1) : i_rs2;
        w_product    = r_neg ? (~r_acc + 1'b1) : r_acc;
    end

`ifdef MUL_EARLY_TERM_EN
    assign w_early = (r_mplier == '0) && (r_cnt < CntW'(XLEN));
`else
    assign w_early = 1'b0;
`endif

    always_comb begin
        w_state_d  = r_state;
        w_acc_d    = r_acc;
        w_mcand_d  = r_mcand;
        w_mplier_d = r_mplier;
        w_cnt_d    = r_cnt;
        w_neg_d    = r_neg;
        w_op_d     = r_op;
        w_result_d = r_result;

        case (r_state)
            StIdle: begin
                if (i_in_valid) begin
                    w_neg_d    = w_rs1_neg ^ w_rs2_neg;
                    w_mcand_d  = {{XLEN{1'b0}}, w_rs1_mag};
                    w_mplier_d = w_rs2_mag;
                    w_acc_d    = '0;
                    w_cnt_d    = '0;
                    w_op_d     = i_op;
                    w_state_d  = StCalc;
                end
            end
            StCalc: begin
                if (w_early) begin
                    w_state_d = StFix;
                end else begin
                    if (r_mplier[0]) begin
                        w_acc_d = r_acc + r_mcand;
                    end
                    w_mplier_d = r_mplier >> 1;
                    w_mcand_d  = r_mcand << 1;
                    w_cnt_d    = r_cnt + 1'b1;
                    if (r_cnt == CntW'(XLEN - 1)) begin
                        w_state_d = StFix;
                    end
                end
            end
            StFix: begin
                w_result_d = (r_op == OpMul) ? w_product[XLEN-1:0] : w_product[PW-1:XLEN];
                w_state_d  = StDone;
            end
            StDone: begin
                if (i_out_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_op     <= 2'b00;
            r_result <= '0;
        end else begin
            r_state  <= w_state_d;
            r_acc    <= w_acc_d;
            r_mcand  <= w_mcand_d;
            r_mplier <= w_mplier_d;
            r_cnt    <= w_cnt_d;
            r_neg    <= w_neg_d;
            r_op     <= w_op_d;
            r_result <= w_result_d;
        end
    end

    assign o_in_ready  = (r_state == StIdle) && !i_rst;
    assign o_out_valid = (r_state == StDone);
    assign o_result    = r_result;

endmodule

// File: tb/tb_mul_iter_unit.sv
// Directed self-checking bench for mul_iter_unit; expected latencies follow MUL_EARLY_TERM_EN.
module tb_mul_iter_unit;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_in_valid = 1'b0;
    logic        o_in_ready;
    logic [1:0]  i_op = 2'b00;
    logic [31:0] i_rs1 = '0;
    logic [31:0] i_rs2 = '0;
    logic        o_out_valid;
    logic        i_out_ready = 1'b0;
    logic [31:0] o_result;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef MUL_EARLY_TERM_EN
    localparam int ZeroLat = 3;
`else
    localparam int ZeroLat = 34;
`endif

    mul_iter_unit #(.XLEN(32)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_op        (i_op),
        .i_rs1       (i_rs1),
        .i_rs2       (i_rs2),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_result    (o_result)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble inputs afterwards, and wait for out_valid.
    // lat counts edges from the acceptance edge (inclusive) to the edge raising out_valid.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output bit rdy_seen);
        @(negedge i_clk);
        i_op = op;
        i_rs1 = a;
        i_rs2 = b;
        i_in_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_in_valid = 1'b0;
        i_rs1 = $urandom;
        i_rs2 = $urandom;
        i_op = ~op;
        lat = 1;
        rdy_seen = 1'b0;
        while (!o_out_valid && lat < 100) begin
            if (o_in_ready) rdy_seen = 1'b1;
            @(posedge i_clk);
            #1;
            lat++;
        end
        check("timeout", {31'd0, o_out_valid}, 32'd1);
    endtask

    task automatic take_result();
        @(negedge i_clk);
        i_out_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        int lat;
        bit rdy;
        do_op(op, a, b, lat, rdy);
        check(tag, o_result, exp);
        take_result();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int  lat;
        bit  rdy;
        int  stuck;
        logic [31:0] held;

        // Reset
        @(posedge i_clk);
        #1;
        check("rst_in_ready_low", {31'd0, o_in_ready}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, o_out_valid}, 32'd0);
        check("rst_result", o_result, 32'd0);
        check("rst_in_ready", {31'd0, o_in_ready}, 32'd1);

        // Test 1: 7*6, fixed latency, in_ready low while busy
        do_op(2'b00, 32'd7, 32'd6, lat, rdy);
        check("t1_result", o_result, 32'h0000_002A);
        check("t1_latency", 32'(lat), 32'd34);
        check("t1_in_ready_busy", {31'd0, rdy}, 32'd0);
        check("t1_in_ready_done", {31'd0, o_in_ready}, 32'd0);
        take_result();
        check("t1_hold_after_done", o_result, 32'h0000_002A);
        check("t1_idle_ready", {31'd0, o_in_ready}, 32'd1);

        // Test 2: all-ones operands
        run("t2_mul",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run("t2_mulh",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run("t2_mulhu", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        // Test 3: signedness corners
        run("t3_mulhsu", 2'b10, 32'hFFFF_FFFE, 32'h8000_0000, 32'hFFFF_FFFF);
        run("t3_mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run("t3_mulh_neg", 2'b01, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run("t3_mul_neg",  2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run("t3_mulhsu_pos", 2'b10, 32'd3, 32'hFFFF_FFFF, 32'h0000_0002);
        run("t3_mulhu_big", 2'b11, 32'h8000_0000, 32'd2, 32'h0000_0001);

        // Test 4: back-pressure in DONE
        do_op(2'b00, 32'd1234, 32'd1000, lat, rdy);
        held = o_result;
        check("t4_result", held, 32'd1234000);
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk);
            #1;
            check("t4_valid_hold", {31'd0, o_out_valid}, 32'd1);
            check("t4_result_hold", o_result, 32'd1234000);
            check("t4_in_ready_hold", {31'd0, o_in_ready}, 32'd0);
        end
        take_result();
        check("t4_valid_drop", {31'd0, o_out_valid}, 32'd0);
        check("t4_in_ready_rise", {31'd0, o_in_ready}, 32'd1);

        // Test 5: reset at CALC cycle 10 discards the op
        @(negedge i_clk);
        i_op = 2'b11;
        i_rs1 = 32'hDEAD_BEEF;
        i_rs2 = 32'h1234_5678;
        i_in_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_in_valid = 1'b0;
        repeat (10) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check("t5_rst_valid", {31'd0, o_out_valid}, 32'd0);
        check("t5_rst_in_ready", {31'd0, o_in_ready}, 32'd1);
        check("t5_rst_result", o_result, 32'd0);
        stuck = 0;
        repeat (40) begin
            @(posedge i_clk);
            #1;
            if (o_out_valid) stuck++;
        end
        check("t5_no_pulse", 32'(stuck), 32'd0);
        run("t5_mul",   2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
        run("t5_mulhu", 2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);

        // Test 6: zero multiplier and top-bit multiplier latency
        do_op(2'b00, 32'd5, 32'd0, lat, rdy);
        check("t6_zero_result", o_result, 32'd0);
        check("t6_zero_latency", 32'(lat), 32'(ZeroLat));
        take_result();
        do_op(2'b00, 32'd5, 32'h8000_0000, lat, rdy);
        check("t6_msb_result", o_result, 32'h8000_0000);
        check("t6_msb_latency", 32'(lat), 32'd34);
        take_result();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
